apb_mux_rr: RTL and testbench
=============================

Name: apb_mux_rr

Overview:
- Parametrised NS-to-1 APB multiplexer/arbiter. Successor to the 2-slave-port APB mux.
- Connects NS upstream APB requesters (slave ports APBS_*) to one downstream APB completer (master port APBM_*).
- Arbitrates round-robin and generates its own SETUP/ACCESS sequencing on the downstream side.
- Optional bus-hang timeout returns PSLVERR to the requester.
- Sits between bridge/CPU APB masters and a shared peripheral bus segment.

Parameters:
- DW, 16, data width.
- AW, 16, address width.
- NS, 4, number of upstream ports. Range 2..16.
- TIMEOUT, 0, maximum ACCESS cycles before forced error completion. 0 = timeout disabled. Otherwise 2..65535.

Ports:
- CLK  in  1  clock, all logic on rising edge.
- RESET  in  1  synchronous reset, active-high.
- APBS_PSEL  in  NS  per-port select.
- APBS_PENABLE  in  NS  per-port enable. Ignored for sequencing.
- APBS_PADDR  in  NS*AW  per-port address. Port i at bits [i*AW +: AW].
- APBS_PWDATA  in  NS*DW  per-port write data. Port i at bits [i*DW +: DW].
- APBS_PWRITE  in  NS  per-port write flag.
- APBS_PRDATA  out  DW  read data, broadcast to all ports.
- APBS_PREADY  out  NS  per-port ready.
- APBS_PSLVERR  out  NS  per-port error.
- APBM_PSEL  out  1  downstream select.
- APBM_PENABLE  out  1  downstream enable.
- APBM_PADDR  out  AW  downstream address.
- APBM_PWDATA  out  DW  downstream write data.
- APBM_PWRITE  out  1  downstream write flag.
- APBM_PRDATA  in  DW  downstream read data.
- APBM_PREADY  in  1  downstream ready.
- APBM_PSLVERR  in  1  downstream error.
- GNT  out  NS  one-hot current owner. Zero in IDLE.

Behaviour:
- Registers:
  - state: IDLE, SETUP, ACCESS.
  - own: owner index, clog2(NS) bits.
  - last: last-granted index.
  - cnt: timeout counter, 16 bits.
- Reset (RESET=1 at edge): state=IDLE, own=0, last=NS-1 (port 0 has first priority), cnt=0.
  - Outputs during and after reset: APBM_PSEL=0, APBM_PENABLE=0, GNT=0, all APBS_PREADY=0, all APBS_PSLVERR=0.
  - Reset mid-transfer abandons it. No completion is signalled upstream.
- Round-robin pick: first port with PSEL=1 in order last+1, last+2, … modulo NS.
- IDLE:
  - If any APBS_PSEL is set: own<=pick, last<=pick, state<=SETUP.
  - Otherwise remain in IDLE.
  - Minimum latency from upstream PSEL to downstream PSEL: 1 cycle.
- SETUP:
  - Outputs: APBM_PSEL=1, APBM_PENABLE=0.
  - If APBS_PSEL[own]=1: state<=ACCESS, cnt<=0.
  - If APBS_PSEL[own]=0 (upstream abort): state<=IDLE. Nothing is signalled upstream.
- ACCESS:
  - Outputs: APBM_PSEL=1, APBM_PENABLE=1.
  - Completion occurs when APBM_PREADY=1, or when TIMEOUT≠0 and cnt==TIMEOUT-1 with APBM_PREADY=0.
  - Not complete: cnt<=cnt+1 and stay in ACCESS. Upstream PSEL dropping in ACCESS is ignored; the downstream transfer always runs to completion.
- Completion cycle:
  - APBS_PREADY[own]=1.
  - APBS_PSLVERR[own] = APBM_PSLVERR for a normal completion, or 1 for a timeout completion.
  - Upstream PREADY is combinational from APBM_PREADY. There is no added data-phase latency.
  - Arbitration next state: if any port other than own has PSEL=1, own<=pick over the other ports, last<=that pick, state<=SETUP (back-to-back, no IDLE cycle). Otherwise state<=IDLE.
  - The completing owner is excluded from this pick even though its PSEL is still high. If it is the only requester, it re-wins via IDLE on the following cycle.
- Non-owner ports, and all ports outside the completion cycle: PREADY=0, PSLVERR=0.
- APBS_PRDATA = APBM_PRDATA, combinational and unmasked. On a timeout completion it is forced to 0.
- PADDR/PWDATA/PWRITE mux: always selected by own, combinational. Upstream ports hold these stable for the whole transfer per APB, so they are not captured.
- GNT = onehot(own) in SETUP and ACCESS; 0 in IDLE.
- A timeout downstream abort drops APBM_PSEL the next cycle (or moves to the next SETUP). A late APBM_PREADY is ignored.

Test Plan:
- Idle request: NS=4. Port 2 write to addr 0x0040, data 0xBEEF; PREADY tied 1.
  - APBM_PSEL rises 1 cycle after APBS_PSEL[2], with PENABLE=0.
  - Next cycle: PENABLE=1, APBM_PADDR=0x0040, APBS_PREADY[2]=1 for exactly 1 cycle.
  - Following cycle: IDLE, GNT=0.
- Simultaneous requests: all 4 ports assert together after reset.
  - Grants in order 0,1,2,3.
  - Each transfer is SETUP+ACCESS, 2 cycles, back-to-back with no IDLE cycles: 8 cycles total from first SETUP.
- Fairness: ports 1 and 3 both re-request continuously.
  - Grants alternate 1,3,1,3; neither is granted twice in a row.
- Wait states and error: downstream holds PREADY=0 for 3 ACCESS cycles, then PREADY=1 with PSLVERR=1, PRDATA=0x1234.
  - Owner sees PREADY=1, PSLVERR=1, PRDATA=0x1234 in that cycle only.
  - Other ports see PREADY=0.
- Timeout: TIMEOUT=8, downstream PREADY stuck at 0.
  - On the 8th ACCESS cycle: APBS_PREADY[own]=1, PSLVERR=1, PRDATA=0.
  - APBM_PSEL=0 next cycle.
  - With TIMEOUT=0, the same stimulus hangs indefinitely with no completion.
- Reset and abort:
  - RESET asserted in ACCESS: next cycle APBM_PSEL=0, GNT=0, no upstream PREADY pulse. First grant after reset goes to port 0.
  - Owner drops PSEL in SETUP: returns to IDLE, no PENABLE issued.

Source files
------------

// File: rtl/apb_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : apb_mux_rr
// Brief    : NS-to-1 round-robin APB arbiter/multiplexer with optional
//            ACCESS-phase timeout returning PSLVERR upstream.
// Revision : 1.0 - initial release
// ============================================================================
module apb_mux_rr #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int NS      = 4,
    parameter int TIMEOUT = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [NS-1:0]    APBS_PSEL,
    input  logic [NS-1:0]    APBS_PENABLE,
    input  logic [NS*AW-1:0] APBS_PADDR,
    input  logic [NS*DW-1:0] APBS_PWDATA,
    input  logic [NS-1:0]    APBS_PWRITE,
    output logic [DW-1:0]    APBS_PRDATA,
    output logic [NS-1:0]    APBS_PREADY,
    output logic [NS-1:0]    APBS_PSLVERR,
    output logic             APBM_PSEL,
    output logic             APBM_PENABLE,
    output logic [AW-1:0]    APBM_PADDR,
    output logic [DW-1:0]    APBM_PWDATA,
    output logic             APBM_PWRITE,
    input  logic [DW-1:0]    APBM_PRDATA,
    input  logic             APBM_PREADY,
    input  logic             APBM_PSLVERR,
    output logic [NS-1:0]    GNT
);

    localparam int          c_OW      = $clog2(NS);
    localparam int          c_IW      = c_OW + 1;
    localparam logic [15:0] c_TO_LAST = (TIMEOUT == 0) ? 16'd0 : 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    state_t          r_state,  w_state_nxt;
    logic [c_OW-1:0] r_own,    w_own_nxt;
    logic [c_OW-1:0] r_last,   w_last_nxt;
    logic [15:0]     r_cnt,    w_cnt_nxt;
    logic [c_OW-1:0] w_pick;
    logic            w_pick_vld;
    logic [c_IW-1:0] w_idx;
    logic [NS-1:0]   w_own_oh;
    logic [NS-1:0]   w_req;
    logic            w_timeout;
    logic            w_done;
    logic            w_unused_penable;

    // PENABLE from requesters carries no information we need: sequencing is local.
    assign w_unused_penable = ^APBS_PENABLE;

    assign w_own_oh  = {{(NS-1){1'b0}}, 1'b1} << r_own;
    assign w_timeout = (TIMEOUT != 0) && (r_state == S_ACCESS) && !APBM_PREADY
                       && (r_cnt == c_TO_LAST);
    assign w_done    = (r_state == S_ACCESS) && (APBM_PREADY || w_timeout);

    // The completing owner is masked so a waiting peer always gets the next slot.
    assign w_req = (r_state == S_IDLE) ? APBS_PSEL : (APBS_PSEL & ~w_own_oh);

    // Scan last+NS down to last+1 so the nearest requester after last wins.
    always_comb begin
        w_pick     = '0;
        w_pick_vld = 1'b0;
        w_idx      = '0;
        for (int k = NS; k >= 1; k--) begin
            w_idx = {1'b0, r_last} + c_IW'(k);
            if (w_idx >= c_IW'(NS)) begin
                w_idx = w_idx - c_IW'(NS);
            end
            if (w_req[w_idx[c_OW-1:0]]) begin
                w_pick     = w_idx[c_OW-1:0];
                w_pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_own_nxt   = r_own;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_own_nxt   = w_pick;
                    w_last_nxt  = w_pick;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                if (APBS_PSEL[r_own]) begin
                    w_state_nxt = S_ACCESS;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACCESS: begin
                if (w_done) begin
                    if (w_pick_vld) begin
                        w_own_nxt   = w_pick;
                        w_last_nxt  = w_pick;
                        w_state_nxt = S_SETUP;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 16'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_own   <= '0;
            r_last  <= c_OW'(NS - 1);
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_own   <= w_own_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign APBM_PSEL    = (r_state != S_IDLE);
    assign APBM_PENABLE = (r_state == S_ACCESS);
    assign APBM_PADDR   = APBS_PADDR[int'(r_own)*AW +: AW];
    assign APBM_PWDATA  = APBS_PWDATA[int'(r_own)*DW +: DW];
    assign APBM_PWRITE  = APBS_PWRITE[r_own];

    assign GNT          = APBM_PSEL ? w_own_oh : '0;
    assign APBS_PREADY  = w_done ? w_own_oh : '0;
    assign APBS_PSLVERR = (w_done && (w_timeout || APBM_PSLVERR)) ? w_own_oh : '0;
    // A timed-out access has no valid read data behind it.
    assign APBS_PRDATA  = w_timeout ? '0 : APBM_PRDATA;

endmodule

`default_nettype wire

// File: tb/tb_apb_mux_rr.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_mux_rr
// Brief    : Self-checking bench for apb_mux_rr (NS=4) with TIMEOUT=8 and 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_mux_rr;

    localparam int c_NS = 4;
    localparam int c_AW = 16;
    localparam int c_DW = 16;

    logic             clk;
    logic             r_rst;
    logic [3:0]       r_psel, r_pen, r_pwrite;
    logic [63:0]      r_paddr, r_pwdata;
    logic [15:0]      r_mrdata;
    logic             r_mready, r_mslverr;

    logic [15:0]      w_prdata  [2];
    logic [3:0]       w_prdy    [2];
    logic [3:0]       w_perr    [2];
    logic [3:0]       w_gnt     [2];
    logic             w_mpsel   [2];
    logic             w_mpen    [2];
    logic             w_mpwrite [2];
    logic [15:0]      w_mpaddr  [2];
    logic [15:0]      w_mpwdata [2];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0 has TIMEOUT=8, instance 1 never times out; both share stimulus.
    generate
        for (genvar g = 0; g < 2; g++) begin : g_dut
            apb_mux_rr #(
                .DW(c_DW), .AW(c_AW), .NS(c_NS), .TIMEOUT((g == 0) ? 8 : 0)
            ) u_dut (
                .CLK          (clk),
                .RESET        (r_rst),
                .APBS_PSEL    (r_psel),
                .APBS_PENABLE (r_pen),
                .APBS_PADDR   (r_paddr),
                .APBS_PWDATA  (r_pwdata),
                .APBS_PWRITE  (r_pwrite),
                .APBS_PRDATA  (w_prdata[g]),
                .APBS_PREADY  (w_prdy[g]),
                .APBS_PSLVERR (w_perr[g]),
                .APBM_PSEL    (w_mpsel[g]),
                .APBM_PENABLE (w_mpen[g]),
                .APBM_PADDR   (w_mpaddr[g]),
                .APBM_PWDATA  (w_mpwdata[g]),
                .APBM_PWRITE  (w_mpwrite[g]),
                .APBM_PRDATA  (r_mrdata),
                .APBM_PREADY  (r_mready),
                .APBM_PSLVERR (r_mslverr),
                .GNT          (w_gnt[g])
            );
        end
    endgenerate

    function automatic int tov(input int j);
        return (j == 0) ? 8 : 0;
    endfunction

    // First requester after 'last' in circular order, skipping 'excl'; -1 if none.
    function automatic int pick(input logic [3:0] req, input int last, input int excl);
        for (int k = 1; k <= c_NS; k++) begin
            int idx;
            idx = (last + k) % c_NS;
            if (req[idx] && idx != excl) return idx;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level model: busy/owner/phase plus wait counter per instance.
    int         m_busy [2];
    int         m_acc  [2];
    int         m_own  [2];
    int         m_last [2];
    int         m_cnt  [2];
    bit         m_init;
    logic [3:0] m_rdy0;

    initial begin
        int         own, p;
        bit         done, tmo;
        logic [3:0] oh;
        m_init = 1'b0;
        m_rdy0 = 4'b0;
        for (int j = 0; j < 2; j++) begin
            m_busy[j] = 0; m_acc[j] = 0; m_own[j] = 0; m_last[j] = c_NS - 1; m_cnt[j] = 0;
        end
        forever begin
            @(negedge clk);
            for (int j = 0; j < 2; j++) begin
                own  = m_own[j];
                oh   = 4'(1 << own);
                done = (m_acc[j] != 0) && (r_mready || (tov(j) != 0 && m_cnt[j] == tov(j) - 1));
                tmo  = done && !r_mready;
                if (j == 0) m_rdy0 = done ? oh : 4'b0;
                if (m_init) begin
                    chk($sformatf("m_psel%0d", j),   32'(w_mpsel[j]),   32'(m_busy[j] != 0));
                    chk($sformatf("m_pen%0d", j),    32'(w_mpen[j]),    32'(m_acc[j] != 0));
                    chk($sformatf("m_gnt%0d", j),    32'(w_gnt[j]),     32'((m_busy[j] != 0) ? oh : 4'b0));
                    chk($sformatf("m_paddr%0d", j),  32'(w_mpaddr[j]),  32'(r_paddr[own*16 +: 16]));
                    chk($sformatf("m_pwdata%0d", j), 32'(w_mpwdata[j]), 32'(r_pwdata[own*16 +: 16]));
                    chk($sformatf("m_pwrite%0d", j), 32'(w_mpwrite[j]), 32'(r_pwrite[own]));
                    chk($sformatf("m_prdy%0d", j),   32'(w_prdy[j]),    32'(done ? oh : 4'b0));
                    chk($sformatf("m_perr%0d", j),   32'(w_perr[j]),
                        32'((done && (tmo || r_mslverr)) ? oh : 4'b0));
                    chk($sformatf("m_prdata%0d", j), 32'(w_prdata[j]),  32'(tmo ? 16'h0 : r_mrdata));
                end
                if (r_rst) begin
                    m_busy[j] = 0; m_acc[j] = 0; m_own[j] = 0; m_last[j] = c_NS - 1; m_cnt[j] = 0;
                end else if (m_busy[j] == 0) begin
                    p = pick(r_psel, m_last[j], -1);
                    if (p >= 0) begin
                        m_busy[j] = 1; m_acc[j] = 0; m_own[j] = p; m_last[j] = p;
                    end
                end else if (m_acc[j] == 0) begin
                    if (r_psel[own]) begin
                        m_acc[j] = 1; m_cnt[j] = 0;
                    end else begin
                        m_busy[j] = 0;
                    end
                end else if (done) begin
                    p = pick(r_psel, m_last[j], own);
                    if (p >= 0) begin
                        m_acc[j] = 0; m_own[j] = p; m_last[j] = p;
                    end else begin
                        m_busy[j] = 0; m_acc[j] = 0;
                    end
                end else begin
                    m_cnt[j]++;
                end
            end
            if (r_rst) m_init = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        int stall;
        r_rst = 1'b1; r_psel = '0; r_pen = '0; r_pwrite = '0; r_paddr = '0; r_pwdata = '0;
        r_mrdata = '0; r_mready = 1'b1; r_mslverr = 1'b0;
        step(); step();
        r_rst = 1'b0;
        #2;
        chk("rst_psel", 32'(w_mpsel[0]), 32'd0);
        chk("rst_gnt",  32'(w_gnt[0]),   32'd0);
        chk("rst_prdy", 32'(w_prdy[0]),  32'd0);

        // Single request from idle on port 2.
        step();
        r_psel = 4'b0100; r_pen = 4'b0100; r_pwrite = 4'b0100;
        r_paddr[32 +: 16] = 16'h0040; r_pwdata[32 +: 16] = 16'hBEEF;
        #2;
        chk("t1_idle_psel", 32'(w_mpsel[0]), 32'd0);
        step(); #2;
        chk("t1_setup_psel", 32'(w_mpsel[0]), 32'd1);
        chk("t1_setup_pen",  32'(w_mpen[0]),  32'd0);
        chk("t1_setup_gnt",  32'(w_gnt[0]),   32'h4);
        step(); #2;
        chk("t1_acc_pen",    32'(w_mpen[0]),    32'd1);
        chk("t1_acc_paddr",  32'(w_mpaddr[0]),  32'h0040);
        chk("t1_acc_pwdata", 32'(w_mpwdata[0]), 32'hBEEF);
        chk("t1_acc_pwrite", 32'(w_mpwrite[0]), 32'd1);
        chk("t1_acc_prdy",   32'(w_prdy[0]),    32'h4);
        step();
        r_psel = '0; r_pen = '0;
        #2;
        chk("t1_end_gnt",  32'(w_gnt[0]),  32'd0);
        chk("t1_end_prdy", 32'(w_prdy[0]), 32'd0);

        // All four ports request at once after reset.
        step(); r_rst = 1'b1;
        step(); r_rst = 1'b0; r_psel = 4'hF; r_pen = 4'hF;
        #2;
        chk("t2_idle_gnt", 32'(w_gnt[0]), 32'd0);
        step();
        for (int c = 0; c < 8; c++) begin
            #2;
            chk($sformatf("t2_gnt_c%0d", c),  32'(w_gnt[0]),  32'(4'b0001 << (c / 2)));
            chk($sformatf("t2_pen_c%0d", c),  32'(w_mpen[0]), 32'(c % 2));
            chk($sformatf("t2_prdy_c%0d", c), 32'(w_prdy[0]), 32'((c % 2 == 1) ? (4'b0001 << (c / 2)) : 4'b0));
            step();
            if (c % 2 == 1) r_psel[c / 2] = 1'b0;
        end
        r_pen = r_psel;
        #2;
        chk("t2_end_gnt", 32'(w_gnt[0]), 32'd0);

        // Ports 1 and 3 hammer continuously; grants must alternate.
        r_psel = 4'b1010; r_pen = 4'b1010;
        step();
        for (int c = 0; c < 8; c++) begin
            #2;
            chk($sformatf("t3_gnt_c%0d", c), 32'(w_gnt[0]),
                32'(((c / 2) % 2 == 0) ? 4'b0010 : 4'b1000));
            step();
        end
        r_psel = '0; r_pen = '0;
        step(); #2;
        chk("t3_abort_psel", 32'(w_mpsel[0]), 32'd0);
        chk("t3_abort_pen",  32'(w_mpen[0]),  32'd0);

        // Three wait states, then an error completion with read data.
        r_mready = 1'b0; r_psel = 4'b0001; r_pen = 4'b0001; r_pwrite = 4'b0000;
        step();
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 4) begin
                r_mready = 1'b1; r_mslverr = 1'b1; r_mrdata = 16'h1234;
            end
            #2;
            for (int j = 0; j < 2; j++) begin
                chk($sformatf("t4_prdy%0d_k%0d", j, k), 32'(w_prdy[j]), 32'((k == 4) ? 4'b0001 : 4'b0));
                chk($sformatf("t4_pen%0d_k%0d", j, k),  32'(w_mpen[j]), 32'd1);
            end
        end
        chk("t4_perr",   32'(w_perr[0]),   32'h1);
        chk("t4_prdata", 32'(w_prdata[0]), 32'h1234);
        step();
        r_psel = '0; r_pen = '0; r_mready = 1'b0; r_mslverr = 1'b0;
        #2;
        chk("t4_end_prdy", 32'(w_prdy[0]),  32'd0);
        chk("t4_end_perr", 32'(w_perr[0]),  32'd0);
        chk("t4_end_psel", 32'(w_mpsel[0]), 32'd0);

        // Downstream stuck: instance 0 times out on the 8th ACCESS cycle, instance 1 hangs.
        r_mrdata = 16'hAAAA; r_psel = 4'b0010; r_pen = 4'b0010;
        step();
        for (int k = 1; k <= 8; k++) begin
            step(); #2;
            chk($sformatf("t5_prdy0_k%0d", k), 32'(w_prdy[0]), 32'((k == 8) ? 4'b0010 : 4'b0));
            chk($sformatf("t5_prdy1_k%0d", k), 32'(w_prdy[1]), 32'd0);
        end
        chk("t5_perr0",   32'(w_perr[0]),   32'h2);
        chk("t5_prdata0", 32'(w_prdata[0]), 32'h0);
        chk("t5_prdata1", 32'(w_prdata[1]), 32'hAAAA);
        step();
        r_psel = '0; r_pen = '0;
        #2;
        chk("t5_psel0_after", 32'(w_mpsel[0]), 32'd0);
        chk("t5_psel1_after", 32'(w_mpsel[1]), 32'd1);
        for (int k = 0; k < 20; k++) begin
            step(); #2;
            chk("t5_hang_prdy1", 32'(w_prdy[1]), 32'd0);
            chk("t5_hang_pen1",  32'(w_mpen[1]), 32'd1);
        end

        // Reset while both instances sit in ACCESS.
        r_psel = 4'b0100; r_pen = 4'b0100;
        step(); step(); #2;
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("t6_pen%0d", j),  32'(w_mpen[j]), 32'd1);
            chk($sformatf("t6_prdy%0d", j), 32'(w_prdy[j]), 32'd0);
        end
        r_rst = 1'b1;
        step(); #2;
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("t6_rst_psel%0d", j), 32'(w_mpsel[j]), 32'd0);
            chk($sformatf("t6_rst_gnt%0d", j),  32'(w_gnt[j]),   32'd0);
            chk($sformatf("t6_rst_prdy%0d", j), 32'(w_prdy[j]),  32'd0);
        end
        r_rst = 1'b0; r_psel = 4'hF; r_pen = 4'hF;
        step(); #2;
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("t6_first_gnt%0d", j), 32'(w_gnt[j]),  32'h1);
            chk($sformatf("t6_first_pen%0d", j), 32'(w_mpen[j]), 32'd0);
        end
        // Owner withdraws during SETUP.
        r_psel = '0; r_pen = '0;
        step(); #2;
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("t6_abort_psel%0d", j), 32'(w_mpsel[j]), 32'd0);
            chk($sformatf("t6_abort_pen%0d", j),  32'(w_mpen[j]),  32'd0);
            chk($sformatf("t6_abort_gnt%0d", j),  32'(w_gnt[j]),   32'd0);
        end

        // Randomised traffic, checked every cycle by the model.
        stall = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            for (int i = 0; i < c_NS; i++) begin
                if (m_rdy0[i] || !r_psel[i]) begin
                    r_psel[i] = m_rdy0[i] ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 2) == 0);
                    r_paddr[i*16 +: 16]  = 16'($urandom);
                    r_pwdata[i*16 +: 16] = 16'($urandom);
                    r_pwrite[i]          = 1'($urandom_range(0, 1));
                end else if ($urandom_range(0, 39) == 0) begin
                    r_psel[i] = 1'b0;
                end
            end
            r_pen = r_psel & 4'($urandom);
            if (stall > 0) begin
                stall--;
                r_mready = 1'b0;
            end else begin
                if ($urandom_range(0, 63) == 0) stall = $urandom_range(4, 14);
                r_mready = ($urandom_range(0, 2) != 0);
            end
            r_mslverr = 1'($urandom_range(0, 1));
            r_mrdata  = 16'($urandom);
            r_rst     = ($urandom_range(0, 499) == 0);
        end
        step(); step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
